// File: rtl/qracc_psum_tiler.sv
// Partial-sum tiler: issues (row, column) tile requests, accumulates MAC partial
// sums across row tiles with signed saturation, and hands out one result per column.
module qracc_psum_tiler #(
    parameter int numOutputs      = 32,
    parameter int accumulatorBits = 16,
    parameter int psumBits        = 20,
    parameter int maxRowTiles     = 16,
    parameter int maxColTiles     = 64,
    localparam int rowIdxBits     = $clog2(maxRowTiles),
    localparam int colIdxBits     = $clog2(maxColTiles)
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                clear_i,
    input  logic                                start_i,
    input  logic [rowIdxBits:0]                 num_row_tiles_i,
    input  logic [colIdxBits:0]                 num_col_tiles_i,
    output logic                                tile_req_valid_o,
    input  logic                                tile_req_ready_i,
    output logic [rowIdxBits-1:0]               tile_row_idx_o,
    output logic [colIdxBits-1:0]               tile_col_idx_o,
    input  logic                                mac_valid_i,
    input  logic [numOutputs*accumulatorBits-1:0] mac_data_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [numOutputs*psumBits-1:0]      out_data_o,
    output logic [colIdxBits-1:0]               out_col_idx_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                overflow_o,
    output logic                                protocol_err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MAC, OUTPUT} state_t;

    localparam logic [rowIdxBits:0] ROW_ONE = (rowIdxBits+1)'(1);
    localparam logic [rowIdxBits:0] ROW_MAX = (rowIdxBits+1)'(maxRowTiles);
    localparam logic [colIdxBits:0] COL_ONE = (colIdxBits+1)'(1);
    localparam logic [colIdxBits:0] COL_MAX = (colIdxBits+1)'(maxColTiles);
    localparam logic [psumBits-1:0] PSUM_MAX = {1'b0, {(psumBits-1){1'b1}}};
    localparam logic [psumBits-1:0] PSUM_MIN = {1'b1, {(psumBits-1){1'b0}}};

    state_t                  state, next_state;
    logic [rowIdxBits:0]     row_cnt;
    logic [colIdxBits:0]     col_cnt;
    logic [rowIdxBits-1:0]   row_idx;
    logic [colIdxBits-1:0]   col_idx;
    logic [psumBits-1:0]     acc      [numOutputs];
    logic [psumBits-1:0]     acc_next [numOutputs];
    logic                    sat_any;
    logic                    row_last, col_last;
    logic                    job_start, acc_en, row_adv, col_adv, job_done, mac_err;

    function automatic logic [rowIdxBits:0] clamp_rows(input logic [rowIdxBits:0] n);
        if (n == '0)     return ROW_ONE;
        if (n > ROW_MAX) return ROW_MAX;
        return n;
    endfunction

    function automatic logic [colIdxBits:0] clamp_cols(input logic [colIdxBits:0] n);
        if (n == '0)     return COL_ONE;
        if (n > COL_MAX) return COL_MAX;
        return n;
    endfunction

    assign row_last = (({1'b0, row_idx} + ROW_ONE) == row_cnt);
    assign col_last = (({1'b0, col_idx} + COL_ONE) == col_cnt);

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) state <= IDLE;
        else      state <= next_state;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state       = state;
        busy_o           = 1'b1;
        tile_req_valid_o = 1'b0;
        out_valid_o      = 1'b0;
        job_start        = 1'b0;
        acc_en           = 1'b0;
        row_adv          = 1'b0;
        col_adv          = 1'b0;
        job_done         = 1'b0;
        mac_err          = mac_valid_i && (state != WAIT_MAC);
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    job_start  = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                tile_req_valid_o = 1'b1;
                if (tile_req_ready_i) next_state = WAIT_MAC;
            end
            WAIT_MAC: begin
                if (mac_valid_i) begin
                    acc_en = 1'b1;
                    if (row_last) next_state = OUTPUT;
                    else begin
                        row_adv    = 1'b1;
                        next_state = ISSUE;
                    end
                end
            end
            OUTPUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (col_last) begin
                        job_done   = 1'b1;
                        next_state = IDLE;
                    end else begin
                        col_adv    = 1'b1;
                        next_state = ISSUE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        // Abort wins over everything, including a pending done or error.
        if (clear_i) begin
            next_state = IDLE;
            job_start  = 1'b0;
            acc_en     = 1'b0;
            row_adv    = 1'b0;
            col_adv    = 1'b0;
            job_done   = 1'b0;
            mac_err    = 1'b0;
        end
    end

    always_comb begin : accumulate
        logic [psumBits-1:0] mac_ext;
        logic [psumBits:0]   sum;
        sat_any = 1'b0;
        for (int k = 0; k < numOutputs; k++) begin
            mac_ext = {{(psumBits-accumulatorBits){mac_data_i[k*accumulatorBits+accumulatorBits-1]}},
                       mac_data_i[k*accumulatorBits +: accumulatorBits]};
            sum = {acc[k][psumBits-1], acc[k]} + {mac_ext[psumBits-1], mac_ext};
            if (row_idx == '0) begin
                acc_next[k] = mac_ext;
            end else if (sum[psumBits] != sum[psumBits-1]) begin
                acc_next[k] = sum[psumBits] ? PSUM_MIN : PSUM_MAX;
                sat_any     = 1'b1;
            end else begin
                acc_next[k] = sum[psumBits-1:0];
            end
        end
    end

    // NOTE: accumulators live in flops rather than a RAM, so they can and do reset to 0.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            row_cnt        <= '0;
            col_cnt        <= '0;
            row_idx        <= '0;
            col_idx        <= '0;
            done_o         <= 1'b0;
            overflow_o     <= 1'b0;
            protocol_err_o <= 1'b0;
            for (int k = 0; k < numOutputs; k++) acc[k] <= '0;
        end else if (clear_i) begin
            row_cnt        <= '0;
            col_cnt        <= '0;
            row_idx        <= '0;
            col_idx        <= '0;
            done_o         <= 1'b0;
            overflow_o     <= 1'b0;
            protocol_err_o <= 1'b0;
            for (int k = 0; k < numOutputs; k++) acc[k] <= '0;
        end else begin
            done_o <= job_done;
            if (job_start) begin
                row_cnt        <= clamp_rows(num_row_tiles_i);
                col_cnt        <= clamp_cols(num_col_tiles_i);
                row_idx        <= '0;
                col_idx        <= '0;
                overflow_o     <= 1'b0;
                protocol_err_o <= 1'b0;
            end
            if (acc_en) begin
                for (int k = 0; k < numOutputs; k++) acc[k] <= acc_next[k];
                if (sat_any) overflow_o <= 1'b1;
            end
            if (row_adv) row_idx <= row_idx + 1'b1;
            if (col_adv) begin
                col_idx <= col_idx + 1'b1;
                row_idx <= '0;
            end
            if (mac_err) protocol_err_o <= 1'b1;
        end
    end

    assign tile_row_idx_o = row_idx;
    assign tile_col_idx_o = col_idx;
    assign out_col_idx_o  = col_idx;

    for (genvar k = 0; k < numOutputs; k++) begin : g_pack
        assign out_data_o[k*psumBits +: psumBits] = acc[k];
    end

endmodule

// File: tb/tb_qracc_psum_tiler.sv
// Randomized bench for qracc_psum_tiler: a saturating running-sum model per column
// predicts every output element, sticky flag and done pulse.
module tb_qracc_psum_tiler;

    localparam int NO = 4;
    localparam int AB = 16;
    localparam int PB = 18;
    localparam int MR = 16;
    localparam int MC = 64;
    localparam int RB = 4;
    localparam int CB = 6;
    localparam longint PMAX = (longint'(1) << (PB-1)) - 1;
    localparam longint PMIN = -(longint'(1) << (PB-1));

    logic              clk, nrst, clear_i, start_i;
    logic [RB:0]       num_row_tiles_i;
    logic [CB:0]       num_col_tiles_i;
    logic              tile_req_valid_o, tile_req_ready_i;
    logic [RB-1:0]     tile_row_idx_o;
    logic [CB-1:0]     tile_col_idx_o;
    logic              mac_valid_i;
    logic [NO*AB-1:0]  mac_data_i;
    logic              out_valid_o, out_ready_i;
    logic [NO*PB-1:0]  out_data_o;
    logic [CB-1:0]     out_col_idx_o;
    logic              busy_o, done_o, overflow_o, protocol_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int fixed_e0[$];

    qracc_psum_tiler #(
        .numOutputs(NO), .accumulatorBits(AB), .psumBits(PB),
        .maxRowTiles(MR), .maxColTiles(MC)
    ) dut (
        .clk(clk), .nrst(nrst), .clear_i(clear_i), .start_i(start_i),
        .num_row_tiles_i(num_row_tiles_i), .num_col_tiles_i(num_col_tiles_i),
        .tile_req_valid_o(tile_req_valid_o), .tile_req_ready_i(tile_req_ready_i),
        .tile_row_idx_o(tile_row_idx_o), .tile_col_idx_o(tile_col_idx_o),
        .mac_valid_i(mac_valid_i), .mac_data_i(mac_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_col_idx_o(out_col_idx_o),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o),
        .protocol_err_o(protocol_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (done_o === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [63:0] elem(input int k);
        return 64'($signed(out_data_o[k*PB +: PB]));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b1;
        clear_i = 1'b0; start_i = 1'b0; tile_req_ready_i = 1'b0;
        mac_valid_i = 1'b0; out_ready_i = 1'b0; mac_data_i = '0;
        num_row_tiles_i = '0; num_col_tiles_i = '0;
        repeat (2) tick();
        nrst = 1'b0;
        tick();
    endtask

    // abort: 0 = run to completion, 1 = reset during the first WAIT_MAC, 2 = clear in the first OUTPUT
    task automatic run_job(input int rows_req, input int cols_req, input int stall,
                           input bit inj_err, input int abort);
        int rows, cols, n, d;
        bit ovf, ok;
        longint m [NO];
        longint s;
        rows = (rows_req == 0) ? 1 : ((rows_req > MR) ? MR : rows_req);
        cols = (cols_req == 0) ? 1 : ((cols_req > MC) ? MC : cols_req);
        ovf = 1'b0;
        num_row_tiles_i = rows_req[RB:0];
        num_col_tiles_i = cols_req[CB:0];
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        check("ovf_cleared_by_start", overflow_o, 0);
        check("perr_cleared_by_start", protocol_err_o, 0);
        for (int c = 0; c < cols; c++) begin
            for (int r = 0; r < rows; r++) begin
                ok = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    if (tile_req_valid_o === 1'b1) begin ok = 1'b1; break; end
                    tick();
                end
                if (!ok) begin
                    check("tile_req_timeout", 0, 1);
                    fixed_e0.delete();
                    return;
                end
                check("tile_row_idx", tile_row_idx_o, r);
                check("tile_col_idx", tile_col_idx_o, c);
                if (inj_err && c == cols-1 && r == rows-1) begin
                    mac_valid_i = 1'b1;
                    start_i = 1'b1;
                    for (int k = 0; k < NO; k++) mac_data_i[k*AB +: AB] = 16'h1234;
                    tick();
                    mac_valid_i = 1'b0;
                    start_i = 1'b0;
                    check("perr_set", protocol_err_o, 1);
                    check("req_held_after_err", tile_req_valid_o, 1);
                    check("no_restart_row", tile_row_idx_o, r);
                    check("no_restart_col", tile_col_idx_o, c);
                end
                n = $urandom_range(0, 2);
                repeat (n) begin
                    tick();
                    check("req_stable", tile_req_valid_o, 1);
                    check("req_row_stable", tile_row_idx_o, r);
                end
                tile_req_ready_i = 1'b1;
                tick();
                tile_req_ready_i = 1'b0;
                if (abort == 1) begin
                    #2 nrst = 1'b1;
                    #1;
                    check("async_rst_busy", busy_o, 0);
                    check("async_rst_req", tile_req_valid_o, 0);
                    check("async_rst_acc", elem(0), 0);
                    tick();
                    nrst = 1'b0;
                    repeat (3) tick();
                    check("no_done_after_rst", done_cnt, exp_done);
                    check("idle_after_rst", busy_o, 0);
                    fixed_e0.delete();
                    return;
                end
                repeat ($urandom_range(0, 2)) tick();
                for (int k = 0; k < NO; k++) begin
                    if (k == 0 && fixed_e0.size() > 0) d = fixed_e0.pop_front();
                    else d = int'($urandom_range(0, 65535)) - 32768;
                    mac_data_i[k*AB +: AB] = d[AB-1:0];
                    if (r == 0) m[k] = d;
                    else begin
                        s = m[k] + d;
                        if (s > PMAX) begin s = PMAX; ovf = 1'b1; end
                        if (s < PMIN) begin s = PMIN; ovf = 1'b1; end
                        m[k] = s;
                    end
                end
                mac_valid_i = 1'b1;
                tick();
                mac_valid_i = 1'b0;
                check("overflow_flag", overflow_o, ovf);
            end
            check("out_valid_latency", out_valid_o, 1);
            if (abort == 2) begin
                clear_i = 1'b1;
                tick();
                clear_i = 1'b0;
                check("clear_busy", busy_o, 0);
                check("clear_out_valid", out_valid_o, 0);
                check("clear_acc", elem(0), 0);
                repeat (3) begin
                    check("clear_no_done", done_o, 0);
                    tick();
                end
                check("clear_done_count", done_cnt, exp_done);
                fixed_e0.delete();
                return;
            end
            n = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int i = 0; i <= n; i++) begin
                check("out_valid_held", out_valid_o, 1);
                check("out_col_idx", out_col_idx_o, c);
                for (int k = 0; k < NO; k++) check($sformatf("out_data[%0d]", k), elem(k), m[k]);
                if (i < n) tick();
            end
            out_ready_i = 1'b1;
            tick();
            out_ready_i = 1'b0;
        end
        exp_done++;
        check("done_pulse", done_o, 1);
        check("idle_busy", busy_o, 0);
        tick();
        check("done_one_cycle", done_o, 0);
        check("done_count", done_cnt, exp_done);
        check("idle_holds_data", elem(0), m[0]);
        fixed_e0.delete();
    endtask

    initial begin
        do_reset();
        check("rst_busy", busy_o, 0);
        check("rst_req_valid", tile_req_valid_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_done", done_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_perr", protocol_err_o, 0);
        check("rst_out_col", out_col_idx_o, 0);
        check("rst_out_data", out_data_o, 0);

        fixed_e0 = '{5, 7, -2};
        run_job(3, 1, 0, 1'b0, 0);
        check("sum_5_7_m2", elem(0), 10);

        run_job(1, 3, 5, 1'b0, 0);

        // 20 requested rows clamp to 16; 0x7FFF saturates once the sum passes PMAX
        for (int i = 0; i < 20; i++) fixed_e0.push_back(32767);
        run_job(20, 1, -1, 1'b0, 0);
        check("sat_value", elem(0), PMAX);
        check("sat_flag", overflow_o, 1);

        for (int i = 0; i < 16; i++) fixed_e0.push_back(-32768);
        run_job(16, 1, -1, 1'b0, 0);
        check("sat_neg_value", elem(0), PMIN);

        run_job(2, 2, -1, 1'b1, 0);
        check("perr_sticky", protocol_err_o, 1);
        run_job(1, 1, -1, 1'b0, 0);

        run_job(2, 1, -1, 1'b0, 1);
        fixed_e0 = '{3};
        run_job(1, 1, -1, 1'b0, 0);
        check("after_rst_value", elem(0), 3);

        run_job(0, 1, -1, 1'b0, 0);
        run_job(1, 2, -1, 1'b0, 2);

        for (int j = 0; j < 8; j++)
            run_job(int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), -1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time limit");
    end

endmodule
